evr_log_filter: RTL and testbench
=================================

# evr_log_filter

Event-code qualifier in the `evrClk` domain, directly upstream of the event logger FIFO write port. It decides which received event codes reach the log. Each code must pass a per-code enable mask, the logger must not be full, and a programmable rate limit per time window must not be exceeded. Pass and drop counters are kept so firmware can tell when the log is incomplete.

## Interface
Parameters:
- `CW`, 8: event code width; the mask has 2^CW entries.
- `WINDOW_WIDTH`, 16: width of the rate-limit window length.

Ports:
- `evrClk`  in  1  clock; all logic is in this domain.
- `evrReset`  in  1  reset; synchronous, active-high.
- `evrCodeValid`  in  1  qualifies `evrCode` for one cycle.
- `evrCode`  in  CW  received event code.
- `maskWrEnable`  in  1  write strobe for the mask table.
- `maskWrAddr`  in  CW  mask entry to write.
- `maskWrData`  in  1  1 = log this code.
- `windowLength`  in  WINDOW_WIDTH  window length in cycles; 0 = rate limiting disabled.
- `maxPerWindow`  in  8  maximum events logged per window; 0 = rate limiting disabled.
- `clearCounters`  in  1  single-cycle pulse that zeroes both counters.
- `logFull`  in  1  logger FIFO full flag.
- `logValid`  out  1  write enable to the logger FIFO.
- `logCode`  out  CW  code to log.
- `passCount`  out  32  events delivered; wraps.
- `dropCount`  out  16  qualified events dropped; saturates at 0xFFFF.
- `rateLimited`  out  1  high while the current window's quota is exhausted.

## Operation
- Pipeline stage 1 (cycle N+1):
  - Register `evrCodeValid` and `evrCode`.
  - Perform a synchronous read of mask[evrCode].
- Pipeline stage 2 (cycle N+2): an event is **qualified** when all of the following hold:
  - stage-1 valid = 1;
  - code ≠ 0;
  - mask bit = 1.
- Code 0x00 is never qualified and is never counted.
- Decision for a qualified event, in priority order:
  - `logFull`=1 → drop. `dropCount`+1.
  - Rate limiting enabled and `windowCount` == `maxPerWindow` → drop. `dropCount`+1.
  - Otherwise → `logValid`=1, `logCode`=code, `passCount`+1, `windowCount`+1.
- Unqualified events produce no output and change no counter.
- Window timer:
  - Counts 0 .. `windowLength`−1 and wraps.
  - On the wrap cycle, `windowCount` loads 0, or 1 if an event is delivered in that same cycle.
  - While rate limiting is disabled, the timer and `windowCount` are held at 0.
  - A change to `windowLength` takes effect at the next wrap. If the current timer value is ≥ the new length, the timer wraps on the next cycle.
- `rateLimited` = rate limiting enabled AND `windowCount` == `maxPerWindow`.
- Mask writes:
  - Take effect at the next clock edge.
  - A read and a write to the same address in the same cycle return the old value (read-before-write).
- `clearCounters`: both counters become 0 on the next cycle. A coincident increment is lost (clear wins).
- `dropCount` holds at 0xFFFF until cleared. `passCount` wraps from 0xFFFFFFFF to 0.

## Timing
- Latency from `evrCodeValid` to `logValid` is exactly 2 cycles.
- Throughput is one event per cycle, with back-to-back codes accepted.
- `logFull` and the rate-limit state are sampled in stage 2, in the same cycle as the decision.
- `logValid` is a single-cycle pulse per event. `logCode` holds its last value while `logValid`=0.
- Reset values:
  - `logValid`=0, `logCode`=0, `passCount`=0, `dropCount`=0, `rateLimited`=0.
  - All mask entries are 0, so nothing is logged after reset until firmware enables codes.
  - Window timer and `windowCount` are 0.
- Reset mid-operation:
  - Both pipeline stages are flushed.
  - `logValid` is 0 in the cycle after reset is sampled high, and stays 0 for as long as reset is held.
  - Events presented while reset is high are discarded.
- All outputs are registered. `logValid`/`logCode` connect directly to the FIFO `wr_en`/`din`.

## Test plan
- Mask and pipeline:
  - Stimulus: reset; enable mask[0x28] and mask[0x7D]; send codes 0x28, 0x7D, 0x10, 0x00 on consecutive cycles.
  - Required: `logValid` in cycles N+2 and N+3 with codes 0x28 and 0x7D; no other output; `passCount`=2; `dropCount`=0.
- Full back-pressure:
  - Stimulus: hold `logFull`=1; send 5 enabled codes back-to-back; then release and send 1 more.
  - Required: no `logValid` for the first 5; `dropCount`=5; the 6th is delivered; `passCount`=1.
- Rate limit:
  - Stimulus: `windowLength`=100, `maxPerWindow`=3; send an enabled code every cycle for 150 cycles starting at the timer wrap.
  - Required: 3 deliveries in the first window; `rateLimited` high after the 3rd; 3 deliveries again after the wrap; 6 deliveries total.
- Counter edges:
  - Stimulus 1: force 0xFFFF drops, then 1 more. Required: `dropCount` stays 0xFFFF.
  - Stimulus 2: assert `clearCounters` in the same cycle as a delivery. Required: both counters read 0 on the next cycle.
- Mask write collision:
  - Stimulus: write mask[0x55]=1 in the same cycle that 0x55 arrives, then send 0x55 again.
  - Required: the first is not logged; the second is logged.
- Reset mid-flight:
  - Stimulus: send 0x28 (enabled); assert `evrReset` one cycle later.
  - Required: no `logValid`; mask cleared; a subsequent 0x28 is not logged.

Source files
------------

// File: rtl/evr_log_filter.sv
// Event-code qualifier ahead of the event logger FIFO: per-code mask, full back-pressure,
// per-window rate limiting, and pass/drop statistics. Two-stage pipeline, all outputs registered.
module evr_log_filter #(
    parameter int unsigned CW           = 8,
    parameter int unsigned WINDOW_WIDTH = 16
) (
    input  logic                    evrClk,
    input  logic                    evrReset,
    input  logic                    evrCodeValid,
    input  logic [CW-1:0]           evrCode,
    input  logic                    maskWrEnable,
    input  logic [CW-1:0]           maskWrAddr,
    input  logic                    maskWrData,
    input  logic [WINDOW_WIDTH-1:0] windowLength,
    input  logic [7:0]              maxPerWindow,
    input  logic                    clearCounters,
    input  logic                    logFull,
    output logic                    logValid,
    output logic [CW-1:0]           logCode,
    output logic [31:0]             passCount,
    output logic [15:0]             dropCount,
    output logic                    rateLimited
);

    localparam int unsigned DEPTH = 1 << CW;
    localparam int unsigned TW    = WINDOW_WIDTH + 1;

    logic [DEPTH-1:0]        mask_q, mask_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [CW-1:0]           s1_code_q, s1_code_d;
    logic                    s1_mask_q, s1_mask_d;
    logic [WINDOW_WIDTH-1:0] timer_q, timer_d;
    logic [7:0]              win_count_q, win_count_d;
    logic                    log_valid_q, log_valid_d;
    logic [CW-1:0]           log_code_q, log_code_d;
    logic [31:0]             pass_count_q, pass_count_d;
    logic [15:0]             drop_count_q, drop_count_d;
    logic                    rate_limited_q, rate_limited_d;

    logic          rl_en;
    logic          quota_hit;
    logic          qualified;
    logic          deliver;
    logic          drop;
    logic          wrap;
    logic [TW-1:0] timer_inc;

    // Next-state logic for the mask table, both pipeline stages, window timer and counters
    always_comb begin
        mask_d = mask_q;
        if (maskWrEnable) begin
            mask_d[maskWrAddr] = maskWrData;
        end

        // Read uses the pre-write table, giving read-before-write on collisions
        s1_valid_d = evrCodeValid;
        s1_code_d  = evrCode;
        s1_mask_d  = mask_q[evrCode];

        rl_en     = (windowLength != '0) && (maxPerWindow != '0);
        quota_hit = rl_en && (win_count_q == maxPerWindow);
        qualified = s1_valid_q && (s1_code_q != '0) && s1_mask_q;
        deliver   = qualified && !logFull && !quota_hit;
        drop      = qualified && !deliver;

        // Wider compare lets a shortened window wrap on the very next cycle
        timer_inc = {1'b0, timer_q} + TW'(1);
        wrap      = timer_inc >= {1'b0, windowLength};

        timer_d     = '0;
        win_count_d = '0;
        if (rl_en) begin
            if (wrap) begin
                timer_d     = '0;
                win_count_d = deliver ? 8'd1 : 8'd0;
            end else begin
                timer_d     = timer_inc[WINDOW_WIDTH-1:0];
                win_count_d = win_count_q + 8'(deliver);
            end
        end

        log_valid_d    = deliver;
        log_code_d     = deliver ? s1_code_q : log_code_q;
        rate_limited_d = rl_en && (win_count_d == maxPerWindow);

        pass_count_d = pass_count_q + 32'(deliver);
        drop_count_d = drop_count_q;
        if (drop && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
        if (clearCounters) begin
            pass_count_d = '0;
            drop_count_d = '0;
        end
    end

    always_ff @(posedge evrClk) begin
        if (evrReset) begin
            mask_q         <= '0;
            s1_valid_q     <= 1'b0;
            s1_code_q      <= '0;
            s1_mask_q      <= 1'b0;
            timer_q        <= '0;
            win_count_q    <= '0;
            log_valid_q    <= 1'b0;
            log_code_q     <= '0;
            pass_count_q   <= '0;
            drop_count_q   <= '0;
            rate_limited_q <= 1'b0;
        end else begin
            mask_q         <= mask_d;
            s1_valid_q     <= s1_valid_d;
            s1_code_q      <= s1_code_d;
            s1_mask_q      <= s1_mask_d;
            timer_q        <= timer_d;
            win_count_q    <= win_count_d;
            log_valid_q    <= log_valid_d;
            log_code_q     <= log_code_d;
            pass_count_q   <= pass_count_d;
            drop_count_q   <= drop_count_d;
            rate_limited_q <= rate_limited_d;
        end
    end

    assign logValid    = log_valid_q;
    assign logCode     = log_code_q;
    assign passCount   = pass_count_q;
    assign dropCount   = drop_count_q;
    assign rateLimited = rate_limited_q;

endmodule

// File: tb/tb_evr_log_filter.sv
// Directed self-checking bench for evr_log_filter: one task per scenario, hand-computed expectations.
module tb_evr_log_filter;

    logic        evrClk;
    logic        evrReset;
    logic        evrCodeValid;
    logic [7:0]  evrCode;
    logic        maskWrEnable;
    logic [7:0]  maskWrAddr;
    logic        maskWrData;
    logic [15:0] windowLength;
    logic [7:0]  maxPerWindow;
    logic        clearCounters;
    logic        logFull;
    logic        logValid;
    logic [7:0]  logCode;
    logic [31:0] passCount;
    logic [15:0] dropCount;
    logic        rateLimited;

    int checks;
    int errors;

    evr_log_filter #(.CW(8), .WINDOW_WIDTH(16)) dut (
        .evrClk       (evrClk),
        .evrReset     (evrReset),
        .evrCodeValid (evrCodeValid),
        .evrCode      (evrCode),
        .maskWrEnable (maskWrEnable),
        .maskWrAddr   (maskWrAddr),
        .maskWrData   (maskWrData),
        .windowLength (windowLength),
        .maxPerWindow (maxPerWindow),
        .clearCounters(clearCounters),
        .logFull      (logFull),
        .logValid     (logValid),
        .logCode      (logCode),
        .passCount    (passCount),
        .dropCount    (dropCount),
        .rateLimited  (rateLimited)
    );

    initial evrClk = 1'b0;
    always #5 evrClk = ~evrClk;

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge evrClk);
        #1;
    endtask

    task automatic do_reset();
        evrCodeValid  = 1'b0;
        evrCode       = '0;
        maskWrEnable  = 1'b0;
        maskWrAddr    = '0;
        maskWrData    = 1'b0;
        windowLength  = '0;
        maxPerWindow  = '0;
        clearCounters = 1'b0;
        logFull       = 1'b0;
        evrReset      = 1'b1;
        step();
        step();
        evrReset = 1'b0;
    endtask

    task automatic mask_write(input logic [7:0] addr, input logic data);
        maskWrEnable = 1'b1;
        maskWrAddr   = addr;
        maskWrData   = data;
        step();
        maskWrEnable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (logValid !== 1'b0) begin errors++; $display("FAIL reset_logValid got %b want 0", logValid); end
        checks++;
        if (logCode !== 8'h00) begin errors++; $display("FAIL reset_logCode got %h want 00", logCode); end
        checks++;
        if (passCount !== 32'd0) begin errors++; $display("FAIL reset_passCount got %0d want 0", passCount); end
        checks++;
        if (dropCount !== 16'd0) begin errors++; $display("FAIL reset_dropCount got %0d want 0", dropCount); end
        checks++;
        if (rateLimited !== 1'b0) begin errors++; $display("FAIL reset_rateLimited got %b want 0", rateLimited); end
    endtask

    task automatic test_mask_pipeline();
        logic [7:0] codes   [6] = '{8'h28, 8'h7D, 8'h10, 8'h00, 8'h00, 8'h00};
        logic       in_vld  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_vld [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_code[6] = '{8'h00, 8'h28, 8'h7D, 8'h7D, 8'h7D, 8'h7D};
        do_reset();
        mask_write(8'h28, 1'b1);
        mask_write(8'h7D, 1'b1);
        for (int i = 0; i < 6; i++) begin
            evrCodeValid = in_vld[i];
            evrCode      = codes[i];
            step();
            checks++;
            if (logValid !== exp_vld[i] || logCode !== exp_code[i]) begin
                errors++;
                $display("FAIL mask_pipe_cycle%0d got valid=%b code=%h want valid=%b code=%h",
                         i, logValid, logCode, exp_vld[i], exp_code[i]);
            end
        end
        checks++;
        if (passCount !== 32'd2) begin errors++; $display("FAIL mask_pipe_passCount got %0d want 2", passCount); end
        checks++;
        if (dropCount !== 16'd0) begin errors++; $display("FAIL mask_pipe_dropCount got %0d want 0", dropCount); end
    endtask

    task automatic test_full_backpressure();
        int seen;
        seen = 0;
        do_reset();
        mask_write(8'h28, 1'b1);
        logFull = 1'b1;
        for (int i = 0; i < 7; i++) begin
            evrCodeValid = (i < 5);
            evrCode      = 8'h28;
            step();
            if (logValid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL full_no_output got %0d pulses want 0", seen); end
        checks++;
        if (dropCount !== 16'd5) begin errors++; $display("FAIL full_dropCount got %0d want 5", dropCount); end
        logFull      = 1'b0;
        evrCodeValid = 1'b1;
        step();
        evrCodeValid = 1'b0;
        step();
        checks++;
        if (logValid !== 1'b1 || logCode !== 8'h28) begin
            errors++;
            $display("FAIL full_release got valid=%b code=%h want valid=1 code=28", logValid, logCode);
        end
        checks++;
        if (passCount !== 32'd1) begin errors++; $display("FAIL full_passCount got %0d want 1", passCount); end
    endtask

    task automatic test_rate_limit();
        int first_win;
        int total;
        do_reset();
        mask_write(8'h28, 1'b1);
        first_win = 0;
        total     = 0;
        windowLength = 16'd100;
        maxPerWindow = 8'd3;
        // Event k is decided at timer (k+1) mod 100: events 0..98 fall in the first window
        for (int s = 0; s < 152; s++) begin
            evrCodeValid = (s < 150);
            evrCode      = 8'h28;
            step();
            if (logValid === 1'b1) begin
                total++;
                if (s < 99) first_win++;
                if (total == 3) begin
                    checks++;
                    if (rateLimited !== 1'b1) begin
                        errors++;
                        $display("FAIL rate_limited_after_3rd got %b want 1", rateLimited);
                    end
                end
            end
        end
        evrCodeValid = 1'b0;
        checks++;
        if (first_win !== 3) begin errors++; $display("FAIL rate_first_window got %0d want 3", first_win); end
        checks++;
        if (total !== 6) begin errors++; $display("FAIL rate_total got %0d want 6", total); end
        checks++;
        if (passCount !== 32'd6) begin errors++; $display("FAIL rate_passCount got %0d want 6", passCount); end
        checks++;
        if (dropCount !== 16'd144) begin errors++; $display("FAIL rate_dropCount got %0d want 144", dropCount); end
        windowLength = '0;
        maxPerWindow = '0;
    endtask

    task automatic test_counter_edges();
        do_reset();
        mask_write(8'h28, 1'b1);
        logFull = 1'b1;
        evrCode = 8'h28;
        for (int i = 0; i < 65535; i++) begin
            evrCodeValid = 1'b1;
            step();
        end
        evrCodeValid = 1'b0;
        step();
        step();
        checks++;
        if (dropCount !== 16'hFFFF) begin errors++; $display("FAIL drop_reach_max got %h want FFFF", dropCount); end
        evrCodeValid = 1'b1;
        step();
        evrCodeValid = 1'b0;
        step();
        step();
        checks++;
        if (dropCount !== 16'hFFFF) begin errors++; $display("FAIL drop_saturate got %h want FFFF", dropCount); end
        // Clear coincides with the edge that would record a delivery
        logFull      = 1'b0;
        evrCodeValid = 1'b1;
        step();
        evrCodeValid  = 1'b0;
        clearCounters = 1'b1;
        step();
        clearCounters = 1'b0;
        checks++;
        if (logValid !== 1'b1) begin errors++; $display("FAIL clear_delivery got valid=%b want 1", logValid); end
        checks++;
        if (passCount !== 32'd0 || dropCount !== 16'd0) begin
            errors++;
            $display("FAIL clear_counters got pass=%0d drop=%0d want 0 0", passCount, dropCount);
        end
    endtask

    task automatic test_mask_collision();
        int seen;
        do_reset();
        maskWrEnable = 1'b1;
        maskWrAddr   = 8'h55;
        maskWrData   = 1'b1;
        evrCodeValid = 1'b1;
        evrCode      = 8'h55;
        step();
        maskWrEnable = 1'b0;
        evrCodeValid = 1'b0;
        step();
        checks++;
        if (logValid !== 1'b0) begin errors++; $display("FAIL collision_first got valid=%b want 0", logValid); end
        evrCodeValid = 1'b1;
        step();
        evrCodeValid = 1'b0;
        seen = 0;
        step();
        if (logValid === 1'b1 && logCode === 8'h55) seen = 1;
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL collision_second got valid=%b code=%h want valid=1 code=55", logValid, logCode);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        do_reset();
        mask_write(8'h28, 1'b1);
        evrCodeValid = 1'b1;
        evrCode      = 8'h28;
        step();
        evrReset = 1'b1;
        step();
        checks++;
        if (logValid !== 1'b0) begin errors++; $display("FAIL midreset_flush got valid=%b want 0", logValid); end
        step();
        checks++;
        if (logValid !== 1'b0) begin errors++; $display("FAIL midreset_held got valid=%b want 0", logValid); end
        evrReset = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            evrCodeValid = (i == 0);
            step();
            if (logValid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_mask_cleared got %0d pulses want 0", seen); end
        checks++;
        if (passCount !== 32'd0 || dropCount !== 16'd0) begin
            errors++;
            $display("FAIL midreset_counters got pass=%0d drop=%0d want 0 0", passCount, dropCount);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        evrReset = 1'b1;
        test_reset();
        test_mask_pipeline();
        test_full_backpressure();
        test_rate_limit();
        test_counter_edges();
        test_mask_collision();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
